// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: MIPS funct codes and sequencer state encoding.
package alu_pkg;

    localparam logic [5:0] AND   = 6'd36;
    localparam logic [5:0] OR    = 6'd37;
    localparam logic [5:0] ADD   = 6'd32;
    localparam logic [5:0] SUB   = 6'd34;
    localparam logic [5:0] SLT   = 6'd42;
    localparam logic [5:0] SLTU  = 6'd43;
    localparam logic [5:0] SLL   = 6'd0;
    localparam logic [5:0] SRL   = 6'd2;
    localparam logic [5:0] SRA   = 6'd3;
    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] DIVU  = 6'd27;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the EX-stage controller (master) and seq_alu (slave).
interface seq_alu_if #(parameter int unsigned WIDTH = 32);

    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;
    logic [WIDTH-1:0] hiOut;
    logic             zero;
    logic             illegal;

    modport master (
        output start, Signal, dataA, dataB,
        input  busy, done, dataOut, hiOut, zero, illegal
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output busy, done, dataOut, hiOut, zero, illegal
    );

endinterface

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU ops. MULTU/DIVU are legal here but produce 0; the sequencer handles them.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = dataB[SW-1:0];

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (Signal)
            AND:   result = dataA & dataB;
            OR:    result = dataA | dataB;
            ADD:   result = dataA + dataB;
            SUB:   result = dataA - dataB;
            SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            SLTU:  result = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
            SLL:   result = dataA << shamt;
            SRL:   result = dataA >> shamt;
            SRA:   result = $unsigned($signed(dataA) >>> shamt);
            MULTU: result = '0;
            DIVU:  result = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops via alu_comb_unit, shift-add MULTU and restoring DIVU
// at one bit per cycle, with a start/busy/done handshake and registered results.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;     // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] comb_result;
    logic             comb_illegal;

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .Signal  (bus.Signal),
        .dataA   (bus.dataA),
        .dataB   (bus.dataB),
        .result  (comb_result),
        .illegal (comb_illegal)
    );

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic             div_ge;
    logic [WIDTH:0]   div_sub;
    logic [WIDTH-1:0] acc_nx, mq_nx;

    // One iteration of whichever multi-cycle op is in flight.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
        div_rem = {acc_q, mq_q[WIDTH-1]};
        div_ge  = (div_rem >= {1'b0, opb_q});
        div_sub = div_rem - {1'b0, opb_q};
        if (state_q == DIV) begin
            acc_nx = div_ge ? div_sub[WIDTH-1:0] : div_rem[WIDTH-1:0];
            mq_nx  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            mq_nx  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opb_d   = opb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ill_d = 1'b0;
                    cnt_d = '0;
                    if (bus.Signal == MULTU || (bus.Signal == DIVU && bus.dataB != '0)) begin
                        state_d = (bus.Signal == MULTU) ? MUL : DIV;
                        busy_d  = 1'b1;
                        acc_d   = '0;
                        mq_d    = bus.dataA;
                        opb_d   = bus.dataB;
                    end else if (bus.Signal == DIVU) begin
                        dout_d = '1;
                        hi_d   = bus.dataA;
                        zero_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        dout_d = comb_result;
                        hi_d   = '0;
                        zero_d = (comb_result == '0);
                        ill_d  = comb_illegal;
                        done_d = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                acc_d = acc_nx;
                mq_d  = mq_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = mq_nx;
                    hi_d    = acc_nx;
                    zero_d  = (mq_nx == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opb_q   <= opb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dataOut = dout_q;
    assign bus.hiOut   = hi_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = ill_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU, successor to the 32-bit single-cycle funct-coded ALU. It executes the same MIPS funct-coded logic and arithmetic ops in one cycle, adds shifts, unsigned compare and signed SLT, and adds iterative MULTU/DIVU that take WIDTH cycles. A start/busy/done handshake lets the EX-stage controller stall while a multi-cycle op runs. Results and the HI word (product high half or remainder) stay registered until the next accepted start.

## Interface
- WIDTH, 32, operand/result width; power of two, 4..64
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; asserted when 0
- start  input  1  request; sampled only when busy=0
- Signal  input  6  funct code, sampled with start
- dataA  input  WIDTH  operand A, sampled with start
- dataB  input  WIDTH  operand B / shift amount, sampled with start
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse; dataOut/hiOut valid from this cycle on
- dataOut  output  WIDTH  result; quotient for DIVU; product low half for MULTU
- hiOut  output  WIDTH  product high half (MULTU) or remainder (DIVU); 0 for other ops
- zero  output  1  dataOut == 0, registered with dataOut
- illegal  output  1  last accepted Signal was unsupported

## Operation
- Funct codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42 (signed), SLTU 43, SLL 0, SRL 2, SRA 3, MULTU 25, DIVU 27.
- Shift amount = dataB[$clog2(WIDTH)-1:0]; shifts apply to dataA.
- ADD/SUB wrap modulo 2^WIDTH and produce no overflow trap.
- SLT/SLTU result is 0 or 1, zero-extended.
- FSM states:
  - IDLE: start=1 with a single-cycle op → registers loaded, stays in IDLE.
  - IDLE: start=1 with MULTU → MUL. With DIVU and dataB≠0 → DIV.
  - MUL / DIV: count WIDTH iterations, then → IDLE.
- MULTU: shift-add, one multiplier bit per cycle; 2·WIDTH-bit product → {hiOut, dataOut}.
- DIVU: restoring division, one quotient bit per cycle.
- DIVU by 0: single-cycle result; dataOut = all ones, hiOut = dataA.
- Unsupported funct: single-cycle; dataOut = 0, hiOut = 0, illegal = 1. Otherwise illegal = 0 on every accepted start.
- start while busy=1: ignored, no effect on any state.
- Reset (any time, including mid-MULTU/DIVU): state IDLE, iteration counter 0, all outputs 0, partial result discarded.

## Timing
- Start accepted at edge k.
- Single-cycle op or DIVU-by-0:
  - Results registered at edge k; done=1 for the cycle after edge k.
  - busy stays 0.
- MULTU / DIVU:
  - busy=1 from edge k to edge k+WIDTH.
  - Iterations run at edges k+1..k+WIDTH.
  - At edge k+WIDTH: busy falls, done=1 for one cycle, dataOut/hiOut/zero update.
- dataOut/hiOut/zero are not updated before done; they hold the previous result while busy.
- Back-to-back: start may be high in the done cycle and is accepted (busy=0 then), so single-cycle ops sustain one per cycle.
- Iteration counter is $clog2(WIDTH)+1 bits and saturates nowhere: it is loaded 0 at start and compared to WIDTH-1.

## Structure
- Package alu_pkg holds:
  - the funct localparams (AND..DIVU);
  - a state enum {IDLE, MUL, DIV}.
- Sub-module alu_comb_unit (WIDTH parameter), purely combinational:
  - inputs Signal, dataA, dataB;
  - outputs result and an illegal flag for single-cycle ops.
- seq_alu holds the FSM, the counter, the MUL/DIV datapath registers (accumulator, shift register) and the output registers.

## Test plan
All scenarios use WIDTH=32.
- Reset mid-op: MULTU start, reset low for 1 cycle after 10 cycles → immediately busy=0, done=0, dataOut=0, hiOut=0; next ADD 2+3 → dataOut=5 one cycle later.
- Single-cycle ops, back-to-back starts:
  - SUB 5-7 → 0xFFFFFFFE
  - SLT 0xFFFFFFFF,1 → 1
  - SLTU same operands → 0
  - SRA 0x80000000 by 4 → 0xF8000000
  - each with done one cycle after its start, busy never 1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy for 32 cycles, done at edge k+32;
  - hiOut=0xFFFFFFFE, dataOut=0x00000001;
  - start pulses during busy ignored.
- DIVU 100/7 → dataOut=14, hiOut=2 after 32 cycles. DIVU 9/0 → dataOut=0xFFFFFFFF, hiOut=9, done after 1 cycle, busy stays 0.
- Illegal funct 6'b111111 with A=B=1 → dataOut=0, zero=1, illegal=1; following AND 0xF0,0x3C → 0x30, illegal=0, zero=0.
